// File: rtl/alu_share_arbiter_if.sv
// Requester-side handshake bundle for alu_share_arbiter.
// Signal suffixes are from the arbiter's point of view.
//   req_valid_i/req_ready_o      : request handshake, bit n = requester n
//   req{0,1}_ctrl_i/_a_i/_b_i    : per-requester ALU code and operands
//   rsp_valid_o/rsp_ready_i      : response handshake, bit n = requester n
//   rsp_data_o                   : shared response data
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [4:0]        req0_ctrl_i;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [4:0]        req1_ctrl_i;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req1_b_i;
    logic [1:0]        rsp_valid_o;
    logic [1:0]        rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;

    // requester side
    modport master (
        output req_valid_i,
        output req0_ctrl_i,
        output req0_a_i,
        output req0_b_i,
        output req1_ctrl_i,
        output req1_a_i,
        output req1_b_i,
        output rsp_ready_i,
        input  req_ready_o,
        input  rsp_valid_o,
        input  rsp_data_o
    );

    // arbiter side
    modport slave (
        input  req_valid_i,
        input  req0_ctrl_i,
        input  req0_a_i,
        input  req0_b_i,
        input  req1_ctrl_i,
        input  req1_a_i,
        input  req1_b_i,
        input  rsp_ready_i,
        output req_ready_o,
        output rsp_valid_o,
        output rsp_data_o
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the execute stage (requester 0) and an auxiliary
// unit (requester 1). One operation in flight: IDLE -> EXEC -> RESP.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   bus (slave)      : request/response handshakes, see alu_share_arbiter_if
//   alu_ctrl_o/a_o/b_o : latched code and operands to the shared ALU
//   alu_res_i        : shared ALU result, sampled ALU_LAT cycles after issue
//   busy_o           : high whenever not IDLE
// Build option: define ALU_SHARE_RR_EN for round-robin arbitration,
// otherwise requester 0 has fixed priority.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    alu_share_arbiter_if.slave bus,
    output logic [4:0]        alu_ctrl_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_res_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [4:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic              grant;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;

`ifdef ALU_SHARE_RR_EN
    // On a tie, alternate away from the last winner.
    always_comb begin
        if (&bus.req_valid_i) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req_valid_i[1];
        end
    end
`else
    // Requester 1 only wins when requester 0 is idle.
    always_comb begin
        grant = ~bus.req_valid_i[0];
    end
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i[grant]) begin
                    req_ready[grant] = 1'b1;
                    ctrl_d       = grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                    a_d          = grant ? bus.req1_a_i : bus.req0_a_i;
                    b_d          = grant ? bus.req1_b_i : bus.req0_b_i;
                    owner_d      = grant;
                    last_grant_d = grant;
                    cnt_d        = 4'd0;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = alu_res_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                // No bypass: the next accept happens from IDLE.
                if (bus.rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ctrl_q       <= 5'd0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_data_o  = res_q;

    // Always fed from the latches so the ALU inputs hold through EXEC.
    assign alu_ctrl_o = ctrl_q;
    assign alu_a_o    = a_q;
    assign alu_b_o    = b_q;
    assign busy_o     = (state_q != IDLE);

endmodule
